mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the unified cache/memory system (mem_system).
- Shares the single Addr/DataIn/Rd/Wr/Done port between an instruction-fetch port (read-only) and a data port (read/write).
- Latches the winning request, holds it on the memory-system interface until Done, then returns registered data and hit status to the requester.
- Adds a sticky error flag for protocol violations, memory errors and a hang watchdog.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : I/D two-port arbiter and sequencer for mem_system with sticky
//            error flag and hang watchdog. ARB_ROUND_ROBIN_EN enables
//            round-robin grant on contention (default: D over I).
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_rd,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_cache_hit,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_cache_hit,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_done,
  input  logic        m_cache_hit,
  input  logic        m_err,
  output logic        err
);

  localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_d;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_op_rd;
  logic        r_op_wr;
  logic [7:0]  r_wdog;
  logic        r_mask_i;
  logic        r_mask_d;
  logic [15:0] r_i_data;
  logic [15:0] r_d_data;
  logic        r_i_hit;
  logic        r_d_hit;
  logic        r_i_done;
  logic        r_d_done;
  logic        r_err;
  logic        w_m_rd;
  logic        w_m_wr;
  logic        w_req_i;
  logic        w_req_d;
  logic        w_grant_d;
  logic        w_d_bad;
  logic        w_timeout;
  logic        w_start;

  // A port that just completed is hidden for one IDLE cycle so a slow requester
  // cannot be served twice.
  assign w_req_i   = i_rd & ~r_mask_i;
  assign w_d_bad   = (r_state == S_IDLE) & d_rd & d_wr & ~r_mask_d;
  assign w_req_d   = (d_rd | d_wr) & ~(d_rd & d_wr) & ~r_mask_d;
  assign w_start   = (r_state == S_IDLE) & (w_req_i | w_req_d);
  assign w_timeout = (r_state == S_ISSUE) & ~m_done & (r_wdog == c_WD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_prefer_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_prefer_d <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_rr_prefer_d <= ~r_rr_prefer_d;
    end
  end

  assign w_grant_d = w_req_d & (~w_req_i | r_rr_prefer_d);
`else
  assign w_grant_d = w_req_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m_rd      = 1'b0;
    w_m_wr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_m_rd = r_op_rd;
        w_m_wr = r_op_wr;
        if (m_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_op_rd   <= 1'b0;
      r_op_wr   <= 1'b0;
      r_wdog    <= '0;
      r_mask_i  <= 1'b0;
      r_mask_d  <= 1'b0;
      r_i_data  <= '0;
      r_d_data  <= '0;
      r_i_hit   <= 1'b0;
      r_d_hit   <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_d_bad || ((r_state == S_ISSUE) && m_err) || w_timeout) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_mask_i <= 1'b0;
          r_mask_d <= 1'b0;
          if (w_start) begin
            r_owner_d <= w_grant_d;
            r_addr    <= w_grant_d ? d_addr : i_addr;
            r_op_rd   <= w_grant_d ? d_rd : 1'b1;
            r_op_wr   <= w_grant_d & d_wr;
            if (w_grant_d) begin
              r_wdata <= d_data_in;
            end
          end
        end
        S_ISSUE: begin
          // A timeout returns zero data and a miss to the owner.
          if (m_done || w_timeout) begin
            r_wdog <= '0;
            if (r_owner_d) begin
              r_d_data <= m_done ? m_data_out : 16'h0000;
              r_d_hit  <= m_done & m_cache_hit;
              r_d_done <= 1'b1;
            end else begin
              r_i_data <= m_done ? m_data_out : 16'h0000;
              r_i_hit  <= m_done & m_cache_hit;
              r_i_done <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        S_RESP: begin
          r_mask_i <= ~r_owner_d;
          r_mask_d <= r_owner_d;
        end
        default: begin
          r_mask_i <= 1'b0;
          r_mask_d <= 1'b0;
        end
      endcase
    end
  end

  assign m_addr      = r_addr;
  assign m_data_in   = r_wdata;
  assign m_rd        = w_m_rd;
  assign m_wr        = w_m_wr;
  assign i_data_out  = r_i_data;
  assign i_cache_hit = r_i_hit;
  assign i_done      = r_i_done;
  assign i_stall     = i_rd & ~r_i_done;
  assign d_data_out  = r_d_data;
  assign d_cache_hit = r_d_hit;
  assign d_done      = r_d_done;
  assign d_stall     = (d_rd | d_wr) & ~r_d_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : self-checking bench for mem_arbiter with a memory responder and a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int TIMEOUT = 64;
  localparam int NEVER   = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        i_cache_hit;
  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic        d_cache_hit;
  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_data_out  = 16'hDEAD;
  logic        m_done      = 1'b0;
  logic        m_cache_hit = 1'b0;
  logic        m_err;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_data_out(i_data_out), .i_done(i_done),
    .i_stall(i_stall), .i_cache_hit(i_cache_hit),
    .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
    .d_cache_hit(d_cache_hit),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_done(m_done), .m_cache_hit(m_cache_hit),
    .m_err(m_err), .err(err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory environment: latency per address nibble, hit when latency is 1.
  logic [15:0] resp_mem [256];
  logic [15:0] ref_mem  [256];
  int          lat_tab  [16];
  int          force_lat  = 0;
  int          issue_cyc  = 0;
  int          cur_lat    = 0;
  int          n_unstable = 0;
  logic [15:0] hold_addr;
  logic [15:0] hold_wd;
  logic        hold_wr;

  always @(negedge clk) begin
    m_done      = 1'b0;
    m_cache_hit = 1'b0;
    m_data_out  = 16'hDEAD;
    if (m_rd || m_wr) begin
      if (issue_cyc == 0) begin
        cur_lat   = (force_lat != 0) ? force_lat : lat_tab[m_addr[3:0]];
        hold_addr = m_addr;
        hold_wd   = m_data_in;
        hold_wr   = m_wr;
      end else if (m_addr !== hold_addr || m_wr !== hold_wr || m_rd !== !hold_wr ||
                   (hold_wr && m_data_in !== hold_wd)) begin
        n_unstable++;
      end
      issue_cyc++;
      if (issue_cyc == cur_lat) begin
        if (m_wr) resp_mem[m_addr[7:0]] = m_data_in;
        m_data_out  = resp_mem[m_addr[7:0]];
        m_cache_hit = (cur_lat == 1);
        m_done      = 1'b1;
      end
    end else begin
      issue_cyc = 0;
    end
  end

  // Reference model state: completions since reset drive the RR parity.
  int n_served = 0;

  function automatic bit exp_hit(input logic [15:0] a);
    if (force_lat != 0) return force_lat == 1;
    return lat_tab[a[3:0]] == 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    n_served = 0;
  endtask

  task automatic run_pair(input bit ri, input bit rdd, input bit wrd,
                          input logic [15:0] ia, input logic [15:0] da,
                          input logic [15:0] dw, input bit exp_df);
    bit          want_d;
    bit          d_first;
    logic [15:0] exp_i;
    logic [15:0] exp_d;
    bit          hit_i;
    bit          hit_d;
    int          got_i;
    int          got_d;
    int          first_port;
    int          idle;
    int          unst0;
    want_d  = rdd | wrd;
    d_first = exp_df;
`ifdef ARB_ROUND_ROBIN_EN
    if (ri && want_d) d_first = (n_served % 2) == 1;
`endif
    exp_i = 16'h0;
    exp_d = 16'h0;
    for (int k = 0; k < 2; k++) begin
      if ((k == 0) == d_first) begin
        if (want_d) begin
          if (wrd) ref_mem[da[7:0]] = dw;
          exp_d = ref_mem[da[7:0]];
        end
      end else if (ri) begin
        exp_i = ref_mem[ia[7:0]];
      end
    end
    hit_i = exp_hit(ia);
    hit_d = exp_hit(da);
    unst0 = n_unstable;
    @(negedge clk);
    i_rd = ri; i_addr = ia; d_rd = rdd; d_wr = wrd; d_addr = da; d_data_in = dw;
    got_i = 0; got_d = 0; first_port = -1; idle = 0;
    for (int c = 0; c < 300 && idle < 3; c++) begin
      @(negedge clk);
      if (i_done) begin
        got_i++;
        if (first_port < 0) first_port = 0;
        chk("i_data", i_data_out, exp_i);
        chk("i_hit", i_cache_hit, hit_i);
        i_rd = 1'b0;
      end
      if (d_done) begin
        got_d++;
        if (first_port < 0) first_port = 1;
        chk("d_data", d_data_out, exp_d);
        chk("d_hit", d_cache_hit, hit_d);
        d_rd = 1'b0; d_wr = 1'b0;
      end
      if (got_i >= ri && got_d >= want_d) idle++;
    end
    chk("i_done_count", got_i, ri);
    chk("d_done_count", got_d, want_d);
    if (ri && want_d) chk("grant_order_d_first", first_port, d_first);
    chk("issue_hold", n_unstable - unst0, 0);
    n_served += ri + want_d;
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  typedef struct {
    bit          ri;
    bit          rdd;
    bit          wrd;
    logic [15:0] ia;
    logic [15:0] da;
    logic [15:0] dw;
    bit          exp_d_first;
  } vec_t;

  vec_t        vecs [6];
  int          wr_cyc, rd_cyc, done_at, i_seen, stall_cyc, gi, gd, sel;
  logic        err_pre;
  logic [15:0] exp_v;
  bit          ri, rdd, wrd;
  logic [15:0] ia, da, dw;

  initial begin
    rst = 1'b1; i_rd = 1'b0; i_addr = '0; d_rd = 1'b1; d_wr = 1'b0;
    d_addr = '0; d_data_in = '0; m_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 16'($urandom);
      ref_mem[i]  = resp_mem[i];
    end
    for (int i = 0; i < 16; i++) lat_tab[i] = 1 + $urandom_range(0, 4);
    lat_tab[0] = 1; lat_tab[1] = 3; lat_tab[2] = 1; lat_tab[3] = 5;

    // Reset held two cycles with a pending D read.
    repeat (2) @(negedge clk);
    chk("rst_m_rd", m_rd, 0);       chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);   chk("rst_m_data_in", m_data_in, 0);
    chk("rst_i_done", i_done, 0);   chk("rst_d_done", d_done, 0);
    chk("rst_i_data", i_data_out, 0); chk("rst_d_data", d_data_out, 0);
    chk("rst_i_hit", i_cache_hit, 0); chk("rst_d_hit", d_cache_hit, 0);
    chk("rst_err", err, 0);
    rst = 1'b0; d_rd = 1'b0; n_served = 0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0046, 16'h0031, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0046, 16'h0046, 16'h5A5A, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0045, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1046, 16'hA5A5, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0012, 16'h0013, 16'h0000, 1'b1};
    for (int v = 0; v < 6; v++)
      run_pair(vecs[v].ri, vecs[v].rdd, vecs[v].wrd, vecs[v].ia, vecs[v].da,
               vecs[v].dw, vecs[v].exp_d_first);

    // I hit: m_rd one cycle after sampling, done the cycle after that.
    force_lat = 1;
    resp_mem[8'h10] = 16'h1234; ref_mem[8'h10] = 16'h1234;
    @(negedge clk); i_rd = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    chk("hit_m_rd", m_rd, 1); chk("hit_m_addr", m_addr, 16'h0010);
    chk("hit_early_done", i_done, 0); chk("hit_i_stall", i_stall, 1);
    @(negedge clk);
    chk("hit_i_done", i_done, 1); chk("hit_i_data", i_data_out, 16'h1234);
    chk("hit_i_hit", i_cache_hit, 1); chk("hit_i_stall_done", i_stall, 0);
    chk("hit_m_rd_resp", m_rd, 0);
    i_rd = 1'b0;
    @(negedge clk);
    chk("hit_done_pulse", i_done, 0);
    n_served++;

    // D write miss with ten-cycle memory latency.
    force_lat = 10;
    @(negedge clk); d_wr = 1'b1; d_addr = 16'h0802; d_data_in = 16'hBEEF;
    wr_cyc = 0; done_at = 0; i_seen = 0; stall_cyc = 0;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      @(negedge clk);
      if (m_wr && !m_rd && m_addr == 16'h0802 && m_data_in == 16'hBEEF) wr_cyc++;
      if (i_done) i_seen++;
      if (d_stall) stall_cyc++;
      if (d_done) done_at = c;
    end
    chk("wm_wr_cycles", wr_cyc, 10); chk("wm_done_at", done_at, 11);
    chk("wm_i_done", i_seen, 0); chk("wm_d_data", d_data_out, 16'hBEEF);
    chk("wm_d_hit", d_cache_hit, 0); chk("wm_stall_cycles", stall_cyc, 10);
    chk("wm_i_data_held", i_data_out, 16'h1234);
    d_wr = 1'b0; ref_mem[8'h02] = 16'hBEEF; n_served++;

    // Randomized traffic against the reference model.
    force_lat = 0;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(1, 3);
      ri  = sel[0];
      wrd = sel[1] && ($urandom_range(0, 1) == 1);
      rdd = sel[1] && !wrd;
      ia  = {8'($urandom), 8'($urandom_range(0, 31))};
      da  = {8'($urandom), 8'($urandom_range(0, 31))};
      dw  = 16'($urandom);
      run_pair(ri, rdd, wrd, ia, da, dw, sel[1]);
    end
    chk("no_err_normal", err, 0);

    // d_rd and d_wr together: D ignored, I still served.
    force_lat = 1; exp_v = ref_mem[8'h21];
    @(negedge clk); d_rd = 1'b1; d_wr = 1'b1; i_rd = 1'b1; i_addr = 16'h0021;
    wr_cyc = 0; rd_cyc = 0; gi = 0; gd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_wr) wr_cyc++;
      if (m_rd) rd_cyc++;
      if (i_done) begin gi++; chk("conf_i_data", i_data_out, exp_v); i_rd = 1'b0; end
      if (d_done) gd++;
    end
    chk("conf_m_wr", wr_cyc, 0); chk("conf_m_rd_cycles", rd_cyc, 1);
    chk("conf_i_count", gi, 1);  chk("conf_d_count", gd, 0);
    chk("conf_err", err, 1);
    d_rd = 1'b0; d_wr = 1'b0;

    // Watchdog timeout after TIMEOUT issue cycles.
    do_reset();
    chk("rst_err_clear", err, 0);
    force_lat = 1;
    resp_mem[8'h33] = 16'h7E57; ref_mem[8'h33] = 16'h7E57;
    run_pair(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0033, 16'h0000, 1'b1);
    force_lat = NEVER;
    @(negedge clk); d_rd = 1'b1; d_addr = 16'h0020;
    rd_cyc = 0; done_at = 0; err_pre = 1'b1;
    for (int c = 1; c <= 100 && done_at == 0; c++) begin
      @(negedge clk);
      if (m_rd) rd_cyc++;
      if (c == TIMEOUT) err_pre = err;
      if (d_done) done_at = c;
    end
    chk("to_rd_cycles", rd_cyc, TIMEOUT); chk("to_done_at", done_at, TIMEOUT + 1);
    chk("to_err_before", err_pre, 0);     chk("to_d_data", d_data_out, 0);
    chk("to_d_hit", d_cache_hit, 0);      chk("to_err", err, 1);
    d_rd = 1'b0;
    @(negedge clk);
    chk("to_idle_m_rd", m_rd, 0); chk("to_done_pulse", d_done, 0);
    n_served++;
    force_lat = 1;
    run_pair(1'b1, 1'b0, 1'b0, 16'h0033, 16'h0000, 16'h0000, 1'b0);

    // m_err: ignored outside ISSUE, flags err during ISSUE, access completes.
    do_reset();
    m_err = 1'b1;
    repeat (3) @(negedge clk);
    chk("merr_idle", err, 0);
    force_lat = 3;
    run_pair(1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 16'h0000, 1'b0);
    m_err = 1'b0;
    chk("merr_err", err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
